// File: rtl/io_pwm_led.sv
// Three-channel PWM generator on the dma_io bus. Period and duty values are written to shadow
// registers and only take effect at a period wrap, so the outputs never glitch.
module io_pwm_led #(
    parameter logic [13:0] BASE_ADR = 14'h3100,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic [2:0]  pwm_out,
    output logic        pwm_irq_1shot
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [5:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] prescale_q, prescale_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] duty_sh_q [3];
    logic [CNT_W-1:0] duty_sh_d [3];
    logic [CNT_W-1:0] duty_act_q [3];
    logic [CNT_W-1:0] duty_act_d [3];
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [2:0]       pwm_q, pwm_d;
    logic             irq_q, irq_d;
    logic [2:0]       sel_q, sel_d;
    logic             hit_q, hit_d;

    logic             wr_hit, clr_done, tick, wrap;
    logic [15:0]      cnt_ext;
    logic [31:0]      rd_val;

    // The register window is 8-word aligned, so the upper address bits identify a hit.
    assign wr_hit = dma_io_we & (dma_io_wadr[13:3] == BASE_ADR[13:3]);

    always_comb begin
        ctrl_d       = ctrl_q;
        prescale_d   = prescale_q;
        period_sh_d  = period_sh_q;
        duty_sh_d    = duty_sh_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        pcnt_d       = pcnt_q;
        cnt_d        = cnt_q;
        clr_done     = 1'b0;
        tick         = 1'b0;
        wrap         = 1'b0;

        if (wr_hit) begin
            case (dma_io_wadr[2:0])
                3'd0: ctrl_d       = dma_io_wdata[5:0];
                3'd1: prescale_d   = dma_io_wdata[CNT_W-1:0];
                3'd2: period_sh_d  = dma_io_wdata[CNT_W-1:0];
                3'd3: duty_sh_d[0] = dma_io_wdata[CNT_W-1:0];
                3'd4: duty_sh_d[1] = dma_io_wdata[CNT_W-1:0];
                3'd5: duty_sh_d[2] = dma_io_wdata[CNT_W-1:0];
                3'd6: clr_done     = dma_io_wdata[0];
                default: ;
            endcase
        end

        if (!ctrl_q[0]) begin
            pcnt_d       = '0;
            cnt_d        = '0;
            period_act_d = period_sh_q;
            duty_act_d   = duty_sh_q;
        end else begin
            tick   = (pcnt_q == prescale_q);
            // >= lets a shrunken PRESCALE pull an overshot pcnt back to 0.
            pcnt_d = (pcnt_q >= prescale_q) ? '0 : pcnt_q + ONE;
            if (tick) begin
                if (cnt_q >= period_act_q) begin
                    wrap         = 1'b1;
                    cnt_d        = '0;
                    period_act_d = period_sh_q;
                    duty_act_d   = duty_sh_q;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        end

        done_d = wrap | (done_q & ~clr_done);
        irq_d  = wrap & ctrl_q[5];
        for (int i = 0; i < 3; i++) begin
            pwm_d[i] = (ctrl_q[0] & ctrl_q[1+i] & (cnt_q < duty_act_q[i])) ^ ctrl_q[4];
        end

        hit_d = dma_io_radr_en & (dma_io_radr[13:3] == BASE_ADR[13:3]);
        sel_d = hit_d ? dma_io_radr[2:0] : sel_q;
    end

    always_comb begin
        cnt_ext              = '0;
        cnt_ext[CNT_W-1:0]   = cnt_q;
        rd_val               = '0;
        case (sel_q)
            3'd0: rd_val[5:0]       = ctrl_q;
            3'd1: rd_val[CNT_W-1:0] = prescale_q;
            3'd2: rd_val[CNT_W-1:0] = period_sh_q;
            3'd3: rd_val[CNT_W-1:0] = duty_sh_q[0];
            3'd4: rd_val[CNT_W-1:0] = duty_sh_q[1];
            3'd5: rd_val[CNT_W-1:0] = duty_sh_q[2];
            3'd6: rd_val            = {cnt_ext, 15'd0, done_q};
            default: ;
        endcase
        dma_io_rdata = hit_q ? rd_val : dma_io_rdata_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q       <= '0;
            prescale_q   <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            duty_sh_q    <= '{default: '0};
            duty_act_q   <= '{default: '0};
            pcnt_q       <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            pwm_q        <= '0;
            irq_q        <= 1'b0;
            sel_q        <= '0;
            hit_q        <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            prescale_q   <= prescale_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            pcnt_q       <= pcnt_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            pwm_q        <= pwm_d;
            irq_q        <= irq_d;
            sel_q        <= sel_d;
            hit_q        <= hit_d;
        end
    end

    assign pwm_out       = pwm_q;
    assign pwm_irq_1shot = irq_q;

endmodule
